// File: rtl/fw_loader.sv
// Boot loader: assembles little-endian 32-bit words from a byte stream into the instruction ROM and holds the core in reset until the full image is in.
// Optional trailing checksum byte enabled by defining FW_LOADER_CHECKSUM_EN.
module fw_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              core_reset,
  output logic              core_enable,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam int              TMO_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [16:0]     MAX_WORDS = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       idx_q, idx_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       word_q, word_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef FW_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        busy_st;
  logic        accept;
  logic [15:0] hdr_len;

  assign busy_st = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                   (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept  = rx_valid && busy_st;
  assign hdr_len = {rx_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef FW_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    if (busy_st) begin
      tmo_d = accept ? '0 : tmo_q + TMO_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN0;
          idx_d   = '0;
          bcnt_d  = '0;
          tmo_d   = '0;
`ifdef FW_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_d = hdr_len;
          if ({1'b0, hdr_len} > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (hdr_len == 16'd0) begin
`ifdef FW_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
`ifndef FW_LOADER_CHECKSUM_EN
        // The final write is still on the port this cycle; release the core after it.
        if (we_q && (idx_q == len_q)) begin
          state_d = S_DONE;
        end else
`endif
        if (accept) begin
`ifdef FW_LOADER_CHECKSUM_EN
          csum_d = csum_q + rx_data;
`endif
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              we_d    = 1'b1;
              addr_d  = idx_q[ADDR_W-1:0];
              wdata_d = {rx_data, word_q};
              idx_d   = idx_q + 16'd1;
`ifdef FW_LOADER_CHECKSUM_EN
              if ((idx_q + 16'd1) == len_q) begin
                state_d = S_CSUM;
              end
`endif
            end
          endcase
        end
      end
`ifdef FW_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (busy_st && !accept && (tmo_q == TMO_LAST)) begin
      state_d = S_ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef FW_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef FW_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign rx_ready    = busy_st;
  assign busy        = busy_st;
  assign rom_we      = we_q;
  assign rom_addr    = addr_q;
  assign rom_wdata   = wdata_q;
  assign core_reset  = (state_q != S_DONE);
  assign core_enable = (state_q == S_DONE);
  assign done        = (state_q == S_DONE);
  assign error       = (state_q == S_ERROR);

endmodule
